// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional hardwired r0,
// optional write-to-read bypass, and a sequenced scrub in place of a flop reset.
module regfile_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              clr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic              state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic write_ok;

    assign write_ok = we && !((ZERO_REG0 != 0) && (waddr == '0));
    assign busy     = (state == CLEAR);

    // Control FSM: reset restarts the scrub even if one is already running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else if (state == CLEAR) begin
            if (idx == ADDR_W'(DEPTH - 1)) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + ADDR_W'(1);
            end
        end else if (clr) begin
            state <= CLEAR;
            idx   <= '0;
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else if (write_ok) begin
                mem[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (state == IDLE) begin
            if ((ZERO_REG0 != 0) && (raddr1 == '0)) begin
                rdata1 = '0;
            end else if ((BYPASS != 0) && we && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (state == IDLE) begin
            if ((ZERO_REG0 != 0) && (raddr2 == '0)) begin
                rdata2 = '0;
            end else if ((BYPASS != 0) && we && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default instance plus a ZERO_REG0=0/BYPASS=0 instance
// driven by the same stimulus table, checked through an expected-value queue.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic        busy, nb_busy;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .rdata1(rdata1), .rdata2(rdata2), .busy(busy)
    );

    regfile_param #(.ZERO_REG0(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .busy(nb_busy)
    );

    typedef struct {
        logic        rst, clr, we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1, raddr2;
        logic        chk;
        logic        exp_busy;
        logic [31:0] exp1, exp2, exp_nb1, exp_nb2;
    } vec_t;

    typedef struct {
        int          id;
        logic        busy;
        logic [31:0] e1, e2, n1, n2;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic r, input logic c, input logic w,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic ck, input logic eb,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] n1, input logic [31:0] n2);
        vec_t v;
        v.rst = r; v.clr = c; v.we = w; v.waddr = wa; v.wdata = wd;
        v.raddr1 = ra1; v.raddr2 = ra2; v.chk = ck; v.exp_busy = eb;
        v.exp1 = e1; v.exp2 = e2; v.exp_nb1 = n1; v.exp_nb2 = n2;
        return v;
    endfunction

    task automatic compare(input string name, input int id,
                           input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatch++;
            $display("[TB] FAIL vec%0d %s: got %h, expected %h", id, name, got, want);
        end
    endtask

    // Pops every outstanding expectation and compares against the live outputs.
    task automatic checkOutput();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("busy",      e.id, {31'b0, busy},    {31'b0, e.busy});
            compare("rdata1",    e.id, rdata1,           e.e1);
            compare("rdata2",    e.id, rdata2,           e.e2);
            compare("nb_busy",   e.id, {31'b0, nb_busy}, {31'b0, e.busy});
            compare("nb_rdata1", e.id, nb_rdata1,        e.n1);
            compare("nb_rdata2", e.id, nb_rdata2,        e.n2);
        end
    endtask

    // Inputs change mid-low-phase; outputs are sampled before the next rising edge.
    task automatic applyStimulus(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        rst = v.rst; clr = v.clr; we = v.we; waddr = v.waddr; wdata = v.wdata;
        raddr1 = v.raddr1; raddr2 = v.raddr2;
        if (v.chk) begin
            e.id = id; e.busy = v.exp_busy;
            e.e1 = v.exp1; e.e2 = v.exp2; e.n1 = v.exp_nb1; e.n2 = v.exp_nb2;
            exp_q.push_back(e);
        end
        #2;
        checkOutput();
    endtask

    initial begin
        // Reset scrub: 32 busy cycles with zero reads, then all registers read 0.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 0, 1, 5'(i), 32'hFFFF_FFFF, 5, 6, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0, 0, 0, 0, 0));

        // Bypass versus storage read of a fresh write.
        vecs.push_back(mk(0, 0, 1, 5, 32'hDEAD_BEEF, 5, 5, 1, 0,
                          32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 5, 1, 0,
                          32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF));

        // Register 0: hardwired on the default instance, ordinary storage otherwise.
        vecs.push_back(mk(0, 0, 1, 0, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1234_5678, 32'h1234_5678));

        // clr with a simultaneous write, then writes during the scrub are dropped.
        vecs.push_back(mk(0, 0, 1, 7, 32'hA5A5_A5A5, 7, 0, 1, 0, 32'hA5A5_A5A5, 0, 0, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 1, 9, 32'h1, 9, 7, 1, 0, 32'h1, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 1, 1, 3, 32'hFFFF_FFFF, 3, 7, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Reset arriving mid-scrub restarts the full 32-cycle count.
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1000);
        for (int i = 0; i < 10; i++)
            applyStimulus(mk(0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0), 1001 + i);
        applyStimulus(mk(1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0), 1011);
        for (int i = 0; i < 32; i++)
            applyStimulus(mk(0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0), 1012 + i);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1044);

        // Fill r1..r31 with their index, then read crossing address pairs.
        for (int i = 1; i < 32; i++)
            applyStimulus(mk(0, 0, 1, 5'(i), 32'(i), 5'(i), 0, 1, 0, 32'(i), 0, 0, 0), 2000 + i);
        for (int i = 0; i < 32; i++)
            applyStimulus(mk(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0,
                             32'(i), 32'(31 - i), 32'(i), 32'(31 - i)), 3000 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
